// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Shared types and constants for the multi-op ALU sequencer:
//   - state_e       : sequencer states (IDLE, REQ, RD, CALC, WB, DONE)
//   - OP_*          : opcode values (ADDI..SBCI)
//   - REQ_*         : bus_req code values
//   - is_legal_op() : opcode legality, which depends on the optional
//                     carry-chain feature.
//   Configuration macro: ALU_SEQ_CARRY_CHAIN_EN (makes ADCI/SBCI legal).
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    CALC = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUBI = 4'd2;
  localparam logic [3:0] OP_ANDI = 4'd3;
  localparam logic [3:0] OP_ORI  = 4'd4;
  localparam logic [3:0] OP_XORI = 4'd5;
  localparam logic [3:0] OP_ADCI = 4'd6;
  localparam logic [3:0] OP_SBCI = 4'd7;

  localparam int unsigned REQ_IDLE  = 32'd0;
  localparam int unsigned REQ_READ  = 32'd1;
  localparam int unsigned REQ_ADDR  = 32'd3;
  localparam int unsigned REQ_WRITE = 32'd4;

  // ADCI/SBCI only exist when the carry chain is built in.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: legal = 1'b1;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      OP_ADCI, OP_SBCI: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// ---------------------------------------------------------------------------
// alu_seq_alu
//   Combinational datapath of the sequencer.
//   Ports:
//     a_i      [DATA_W-1:0]  operand A (immediate)
//     b_i      [DATA_W-1:0]  operand B (bus read data)
//     cin_i                  carry flag of the previous op (ADCI/SBCI only)
//     op_i     [3:0]         opcode
//     result_o [DATA_W-1:0]  result modulo 2^DATA_W
//     cout_o                 carry (add) / borrow (subtract); 0 for logic ops
//   Configuration macro: ALU_SEQ_CARRY_CHAIN_EN (adds ADCI/SBCI).
// ---------------------------------------------------------------------------
module alu_seq_alu
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  input  logic [3:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              cout_o
);

  // One extra bit holds the carry out, or the borrow of a subtraction.
  logic [DATA_W:0] ext_s;
  logic [DATA_W:0] cin_ext_s;

  assign cin_ext_s = {{DATA_W{1'b0}}, cin_i};

`ifndef ALU_SEQ_CARRY_CHAIN_EN
  logic unused_cin_s;
  assign unused_cin_s = ^cin_ext_s;
`endif

  // Extended-width result per opcode; logic ops leave the top bit clear.
  always_comb begin
    ext_s = '0;
    case (op_i)
      OP_ADDI: ext_s = {1'b0, a_i} + {1'b0, b_i};
      OP_SUBI: ext_s = {1'b0, a_i} - {1'b0, b_i};
      OP_ANDI: ext_s = {1'b0, a_i & b_i};
      OP_ORI:  ext_s = {1'b0, a_i | b_i};
      OP_XORI: ext_s = {1'b0, a_i ^ b_i};
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      OP_ADCI: ext_s = {1'b0, a_i} + {1'b0, b_i} + cin_ext_s;
      OP_SBCI: ext_s = {1'b0, a_i} - {1'b0, b_i} - cin_ext_s;
`endif
      default: ext_s = '0;
    endcase
  end

  assign result_o = ext_s[DATA_W-1:0];
  assign cout_o   = ext_s[DATA_W];

endmodule

// File: rtl/alu_seq_core.sv
// ---------------------------------------------------------------------------
// alu_seq_core
//   Multi-op ALU sequencer. Accepts opcode+immediate, fetches operand B over
//   the shared bus, computes, writes the result back, then pulses done.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     op_valid / op_ready    operation handshake (ready only in IDLE)
//     opcode [3:0], imm      operation and operand A, latched at accept
//     bus_req [REQ_W-1:0]    bus phase code (IDLE=0, READ=1, ADDR=3, WRITE=4)
//     bus_rdy                target ready, qualifies every bus phase
//     bus_in                 read data (operand B)
//     bus_out, bus_oe        write data and per-bit output enable (WB only)
//     carry, zero            flags of the last completed op
//     done, err              one-cycle completion pulse, illegal-opcode flag
//   Configuration macro: ALU_SEQ_CARRY_CHAIN_EN (ADCI/SBCI use carry flag).
// ---------------------------------------------------------------------------
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int REQ_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] imm,
  output logic [REQ_W-1:0]  bus_req,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] bus_oe,
  output logic              carry,
  output logic              zero,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                op_ready_q, op_ready_d;
  logic [REQ_W-1:0]    bus_req_q, bus_req_d;
  logic [DATA_W-1:0]   bus_out_q, bus_out_d;
  logic [DATA_W-1:0]   bus_oe_q, bus_oe_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_cout_s;

  assign accept_s = op_valid & op_ready_q;

  alu_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .cin_i    (carry_q),
    .op_i     (op_q),
    .result_o (alu_res_s),
    .cout_o   (alu_cout_s)
  );

  // Next-state logic; bus phases hold until bus_rdy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = is_legal_op(opcode) ? REQ : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      REQ:     state_d = bus_rdy ? RD : REQ;
      RD:      state_d = bus_rdy ? CALC : RD;
      CALC:    state_d = WB;
      WB:      state_d = bus_rdy ? DONE : WB;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    bus_req_d  = REQ_W'(REQ_IDLE);
    op_ready_d = (state_d == IDLE);
    done_d     = (state_d == DONE);
    // Only the IDLE->DONE shortcut reaches DONE without a legal opcode.
    err_d      = (state_d == DONE) && (state_q == IDLE);
    bus_oe_d   = (state_d == WB) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    case (state_d)
      REQ:     bus_req_d = REQ_W'(REQ_ADDR);
      RD:      bus_req_d = REQ_W'(REQ_READ);
      WB:      bus_req_d = REQ_W'(REQ_WRITE);
      default: bus_req_d = REQ_W'(REQ_IDLE);
    endcase
    if (state_d == WB) begin
      // Entering WB from CALC loads the result; WB stalls keep it.
      bus_out_d = (state_q == CALC) ? alu_res_s : bus_out_q;
    end else begin
      bus_out_d = '0;
    end
    if (state_q == CALC) begin
      carry_d = alu_cout_s;
      zero_d  = (alu_res_s == '0);
    end else begin
      carry_d = carry_q;
      zero_d  = zero_q;
    end
  end

  // State, operand latches, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      op_ready_q <= 1'b1;
      bus_req_q  <= '0;
      bus_out_q  <= '0;
      bus_oe_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      op_ready_q <= op_ready_d;
      bus_req_q  <= bus_req_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (accept_s) begin
        op_q <= opcode;
        a_q  <= imm;
      end else begin
        op_q <= op_q;
        a_q  <= a_q;
      end
      if ((state_q == RD) && bus_rdy) begin
        b_q <= bus_in;
      end else begin
        b_q <= b_q;
      end
    end
  end

  assign op_ready = op_ready_q;
  assign bus_req  = bus_req_q;
  assign bus_out  = bus_out_q;
  assign bus_oe   = bus_oe_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_core
//   Randomised scoreboard bench for alu_seq_core (DATA_W=4, REQ_W=4).
//   A driver issues operations and pushes the reference result; a monitor
//   pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_alu_seq_core;

  localparam int DW = 4;
  localparam int M  = 1 << DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [3:0]    opcode = 4'd0;
  logic [DW-1:0] imm = '0;
  logic [3:0]    bus_req;
  logic          bus_rdy = 1'b1;
  logic [DW-1:0] bus_in = '0;
  logic [DW-1:0] bus_out;
  logic [DW-1:0] bus_oe;
  logic          carry, zero, done, err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int res;
    int c;
    int z;
    int e;
  } exp_t;

  exp_t sbq[$];
  int   carry_m = 0;
  int   zero_m  = 0;

  alu_seq_core #(.DATA_W(DW), .REQ_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opcode   (opcode),
    .imm      (imm),
    .bus_req  (bus_req),
    .bus_rdy  (bus_rdy),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .carry    (carry),
    .zero     (zero),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t x;
    bit   legal;
    int   s;
    legal = (op >= 1 && op <= 5);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    if (op == 6 || op == 7) legal = 1'b1;
`endif
    x.e   = legal ? 0 : 1;
    x.res = 0;
    if (legal) begin
      case (op)
        1: begin s = a + b; x.res = s % M; carry_m = (s >= M) ? 1 : 0; end
        2: begin carry_m = (a < b) ? 1 : 0; x.res = (a - b + M) % M; end
        3: begin x.res = a & b; carry_m = 0; end
        4: begin x.res = a | b; carry_m = 0; end
        5: begin x.res = a ^ b; carry_m = 0; end
        6: begin s = a + b + carry_m; x.res = s % M; carry_m = (s >= M) ? 1 : 0; end
        7: begin s = a - b - carry_m; x.res = (s + 2 * M) % M; carry_m = (s < 0) ? 1 : 0; end
        default: ;
      endcase
      zero_m = (x.res == 0) ? 1 : 0;
    end
    x.c = carry_m;
    x.z = zero_m;
    return x;
  endfunction

  // mode 0: bus_rdy=1; mode 1: random stalls and noise; mode 2: 3 REQ + 2 WB stalls.
  task automatic run_op(input int op, input int a, input int b, input int mode,
                        input int exp_cycles, input string tag);
    exp_t x;
    int   n, cyc, req_st, wb_st;
    bit   fin;
    opcode   = 4'(op);
    imm      = DW'(a);
    bus_in   = DW'(b);
    bus_rdy  = 1'b1;
    op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_ready) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      op_valid = 1'b0;
      return;
    end
    x = model(op, a, b);
    sbq.push_back(x);
    @(posedge clk); #1;
    // Latched values must not follow later input changes.
    op_valid = 1'b0;
    opcode   = 4'($urandom);
    imm      = DW'($urandom);
    cyc = 1; req_st = 0; wb_st = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      if (done) begin
        fin = 1'b1;
        op_valid = 1'b0;
      end else begin
        case (mode)
          0: bus_rdy = 1'b1;
          1: begin
            bus_rdy  = 1'($urandom_range(0, 1));
            op_valid = 1'($urandom_range(0, 1));
          end
          default: begin
            bus_rdy = 1'b1;
            if (bus_req == 4'd3 && req_st < 3) begin
              bus_rdy = 1'b0;
              req_st++;
            end else if (bus_req == 4'd4 && wb_st < 2) begin
              bus_rdy = 1'b0;
              wb_st++;
              chk({tag, "_wb_hold_data"}, bus_out, x.res);
            end
          end
        endcase
        bus_in = bus_rdy ? DW'(b) : DW'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) begin
      chk({tag, "_done_timeout"}, 0, 1);
    end else begin
      if (exp_cycles > 0) chk({tag, "_latency"}, cyc, exp_cycles);
      chk({tag, "_ready_in_done"}, op_ready, 0);
      bus_rdy = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ready_after"}, op_ready, 1);
    end
  endtask

  // Monitor: tracks bus activity and checks each done against the scoreboard.
  initial begin
    exp_t x;
    bit   wr_seen, bus_seen;
    int   wr_data;
    wr_seen = 1'b0; bus_seen = 1'b0; wr_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_seen = 1'b0;
        bus_seen = 1'b0;
      end else begin
        if (bus_req != 4'd0) bus_seen = 1'b1;
        if (bus_req == 4'd4) begin
          if (bus_oe != 4'hF) chk("oe_in_wb", bus_oe, 15);
          if (bus_rdy) begin
            wr_data = bus_out;
            wr_seen = 1'b1;
          end
        end else if (bus_oe != 4'h0) begin
          chk("oe_outside_wb", bus_oe, 0);
        end
        if (done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            x = sbq.pop_front();
            chk("err", err, x.e);
            chk("carry", carry, x.c);
            chk("zero", zero, x.z);
            if (x.e == 0) begin
              chk("write_seen", wr_seen, 1);
              chk("write_data", wr_data, x.res);
            end else begin
              chk("illegal_no_bus", bus_seen, 0);
            end
          end
          wr_seen = 1'b0;
          bus_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int n, op;
    // Reset state.
    #2;
    chk("reset_outputs", {bus_req, bus_oe, bus_out, carry, zero, done, err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("reset_ready", op_ready, 1);

    // Directed cases.
    run_op(1, 9, 8, 0, 5, "addi_9_8");
    run_op(2, 3, 5, 0, 5, "subi_3_5");
    run_op(3, 12, 3, 0, 5, "andi_zero");
    run_op(1, 7, 6, 2, 10, "stall_addi");
    run_op(0, 5, 5, 0, 1, "illegal_0");
    run_op(15, 2, 2, 0, 1, "illegal_15");
    run_op(1, 15, 1, 0, 5, "addi_15_1");
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    run_op(6, 2, 3, 0, 5, "adci_2_3");
`else
    run_op(6, 2, 3, 0, 1, "adci_illegal");
`endif
    run_op(7, 4, 4, 0, 0, "sbci_4_4");
    run_op(5, 10, 10, 1, 0, "xori_same");

    // Randomised operations, biased towards legal opcodes.
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 7));
      run_op(op, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, 1)), 0, "rand");
    end

    // Reset while reading: leave carry set first so the reset is visible.
    run_op(1, 15, 1, 0, 5, "pre_reset_addi");
    opcode = 4'd1; imm = 4'd5; bus_in = 4'd6; bus_rdy = 1'b1; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    op_valid = 1'b0;
    n = 0;
    while (bus_req != 4'd1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_reached_rd", bus_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus_req, bus_oe, bus_out, carry, zero, done, err}, 0);
    carry_m = 0;
    zero_m  = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", op_ready, 1);
    chk("rst_release_req", bus_req, 0);
    run_op(2, 8, 3, 0, 5, "post_reset_subi");

    // Drain the scoreboard.
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
